// File: rtl/dmem_responder.sv
// Single-port data memory responder: one outstanding request, fixed response latency.
module dmem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned WORDS = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               accept;

    logic [ADDR_W-1:0]  idx;
    logic [3:0]         be;
    logic               bad;
    logic [31:0]        new_rdata;

    logic [31:0]        hold_rdata;
    logic               hold_err;

    logic [31:0]        mem [WORDS];

    // Upper address bits alias onto the same words by design.
    logic               unused_addr;
    assign unused_addr = ^addr[31:ADDR_W+2];

    assign idx    = addr[ADDR_W+1:2];
    assign accept = addr_ok;

    // Byte enables and error classification for the request on the bus.
    always_comb begin
        be  = 4'b0000;
        bad = 1'b0;
        case (size)
            2'd0: be = 4'(4'b0001 << addr[1:0]);
            2'd1: begin
                be  = addr[1] ? 4'b1100 : 4'b0011;
                bad = addr[0];
            end
            2'd2: begin
                be  = 4'b1111;
                bad = (addr[1:0] != 2'b00);
            end
            default: bad = 1'b1;
        endcase
        new_rdata = wr ? 32'h0 : mem[idx];
    end

    // Next-state, counter and acceptance logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_ok   = 1'b0;
        case (state)
            IDLE: begin
                addr_ok = req;
                if (req) begin
                    cnt_nxt   = CNT_W'(LATENCY - 1);
                    state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = RESP;
                end
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Latch the response on acceptance; present it only during the strobe cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_rdata <= 32'h0;
            hold_err   <= 1'b0;
            data_ok    <= 1'b0;
            rdata      <= 32'h0;
            err        <= 1'b0;
        end else begin
            if (accept) begin
                hold_rdata <= new_rdata;
                hold_err   <= bad;
            end
            data_ok <= (state_nxt == RESP);
            if (state_nxt == RESP) begin
                rdata <= accept ? new_rdata : hold_rdata;
                err   <= accept ? bad : hold_err;
            end else begin
                rdata <= 32'h0;
                err   <= 1'b0;
            end
        end
    end

    // Memory array: writes commit on the acceptance edge, never cleared by reset.
    always_ff @(posedge clk) begin
        if (accept && resetn && wr && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed checks of dmem_responder against a timestamp-based model.
module tb_dmem_responder;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned WORDS   = 1 << ADDR_W;

    logic        clk;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    int vectors;
    int miscompares;
    int cyc;

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .addr    (addr),
        .wdata   (wdata),
        .addr_ok (addr_ok),
        .data_ok (data_ok),
        .rdata   (rdata),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [31:0] mmem [WORDS];
    bit        mval [WORDS];
    bit        pend;
    int        resp_cyc;
    bit [31:0] p_rdata;
    bit        p_err;
    bit        p_known;

    function automatic bit is_bad(input logic [1:0] s, input logic [31:0] a);
        int bytes;
        if (s == 2'd3) return 1'b1;
        bytes = 1 << s;
        return (int'(a[1:0]) % bytes) != 0;
    endfunction

    // Model step and output compare, once per cycle away from the active edge.
    always @(negedge clk) begin
        bit exp_dok;
        bit exp_aok;
        int i;
        int lo;
        if (!resetn) begin
            pend = 1'b0;
            chk("rst_addr_ok", 32'(addr_ok), 32'(req));
            chk("rst_data_ok", 32'(data_ok), 32'h0);
            chk("rst_err", 32'(err), 32'h0);
            chk("rst_rdata", rdata, 32'h0);
        end else begin
            exp_dok = pend && (cyc == resp_cyc);
            exp_aok = !pend && req;
            chk("addr_ok", 32'(addr_ok), 32'(exp_aok));
            chk("data_ok", 32'(data_ok), 32'(exp_dok));
            chk("err", 32'(err), exp_dok ? 32'(p_err) : 32'h0);
            if (exp_dok && !p_err && p_known) begin
                chk("rdata", rdata, p_rdata);
            end
            if (exp_dok) pend = 1'b0;
            if (exp_aok) begin
                i        = int'(addr[ADDR_W+1:2]);
                lo       = int'(addr[1:0]);
                pend     = 1'b1;
                resp_cyc = cyc + LATENCY;
                p_err    = is_bad(size, addr);
                p_known  = wr || mval[i];
                p_rdata  = wr ? 32'h0 : mmem[i];
                if (wr && !p_err) begin
                    for (int b = 0; b < 4; b++) begin
                        if (b >= lo && b < lo + (1 << size)) begin
                            mmem[i][8*b +: 8] = wdata[8*b +: 8];
                        end
                    end
                    mval[i] = 1'b1;
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_req(input logic w, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd,
                          output logic er, output int lat);
        int acc_cyc;
        bit got;
        rd  = 32'h0;
        er  = 1'b0;
        lat = -1;
        @(posedge clk);
        #1;
        req = 1'b1; wr = w; size = s; addr = a; wdata = d;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (addr_ok) begin
                got = 1'b1;
                acc_cyc = cyc;
            end
        end
        if (!got) begin
            chk("accept_timeout", 32'h0, 32'h1);
            req = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_5A5A;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (data_ok) begin
                got = 1'b1;
                rd  = rdata;
                er  = err;
                lat = cyc - acc_cyc;
            end
        end
        if (!got) chk("resp_timeout", 32'h0, 32'h1);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          acc_q[$];

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; pend = 1'b0;
        resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data_ok", 32'(data_ok), 32'h0);
        resetn = 1'b1;

        // Word write then read.
        do_req(1'b1, 2'd2, 32'h100, 32'hDEADBEEF, rd, er, lat);
        chk("wr_latency", 32'(lat), 32'(LATENCY));
        chk("wr_err", 32'(er), 32'h0);
        chk("wr_rdata_zero", rd, 32'h0);
        do_req(1'b0, 2'd2, 32'h100, 32'h0, rd, er, lat);
        chk("rd_word", rd, 32'hDEADBEEF);
        chk("rd_err", 32'(er), 32'h0);

        // Byte write into lane 2.
        do_req(1'b1, 2'd0, 32'h102, 32'h00AA0000, rd, er, lat);
        do_req(1'b0, 2'd2, 32'h100, 32'h0, rd, er, lat);
        chk("byte_merge", rd, 32'hDEAABEEF);

        // Misaligned word write is rejected.
        do_req(1'b1, 2'd2, 32'h101, 32'h11111111, rd, er, lat);
        chk("misalign_err", 32'(er), 32'h1);
        do_req(1'b0, 2'd2, 32'h100, 32'h0, rd, er, lat);
        chk("misalign_nochange", rd, 32'hDEAABEEF);

        // Address wrap.
        do_req(1'b1, 2'd2, 32'h0000_1000, 32'h0000_1234, rd, er, lat);
        do_req(1'b0, 2'd2, 32'h0000_0000, 32'h0, rd, er, lat);
        chk("addr_wrap", rd, 32'h0000_1234);

        // Back-to-back: req held high.
        @(posedge clk);
        #1;
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h100;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (addr_ok) acc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        chk("b2b_count", 32'(acc_q.size()), 32'd4);
        if (acc_q.size() >= 2) chk("b2b_spacing", 32'(acc_q[1] - acc_q[0]), 32'(LATENCY + 1));
        repeat (5) @(posedge clk);

        // Reset during WAIT drops the response but keeps the write.
        #1;
        req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h200; wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rst_mid_accept", 32'(addr_ok), 32'h1);
        @(posedge clk);
        #1;
        req = 1'b0; wr = 1'b0; resetn = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h200;
        @(negedge clk);
        chk("post_rst_accept", 32'(addr_ok), 32'h1);
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (LATENCY) @(negedge clk);
        chk("post_rst_data_ok", 32'(data_ok), 32'h1);
        chk("write_survives_rst", rdata, 32'hCAFEF00D);

        // Initialise a small working set, then random traffic with aliasing.
        for (int w = 0; w < 16; w++) begin
            do_req(1'b1, 2'd2, 32'(w * 4), $urandom, rd, er, lat);
        end
        for (int k = 0; k < 1500; k++) begin
            @(posedge clk);
            #1;
            resetn = ($urandom_range(0, 99) != 0);
            req    = ($urandom_range(0, 9) < 7);
            wr     = $urandom_range(0, 1) == 1;
            size   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr   = {20'($urandom), 6'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
            wdata  = $urandom;
        end
        @(posedge clk);
        #1;
        resetn = 1'b1; req = 1'b0;
        repeat (LATENCY + 3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: ADDR_W, default 10, log2 of the word count; memory is 2^ADDR_W x 32 bits.
REQ-002 Parameter: LATENCY, default 2, cycles from request acceptance to response; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  pipeline data request valid.
REQ-006 wr  input  1  1 = write, 0 = read; sampled with req.
REQ-007 size  input  2  access size: 0 = byte, 1 = halfword, 2 = word, 3 = illegal.
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  write data, already placed in its byte lanes.
REQ-010 addr_ok  output  1  request accepted this cycle.
REQ-011 data_ok  output  1  one-cycle response strobe.
REQ-012 rdata  output  32  aligned word read; valid while data_ok is high.
REQ-013 err  output  1  misaligned or illegal-size request; valid while data_ok is high.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-015 In IDLE, addr_ok SHALL equal req combinationally; in WAIT and RESP, addr_ok SHALL be 0.
REQ-016 On an edge with req && addr_ok, the block SHALL latch the request, load the latency counter with LATENCY-1, and enter RESP if LATENCY == 1, otherwise WAIT.
REQ-017 In WAIT, the counter SHALL decrement each cycle; on the edge where it reaches 0, the state SHALL become RESP.
REQ-018 In RESP, data_ok SHALL be 1 for exactly one cycle, and the state SHALL return to IDLE on the next edge.
REQ-019 data_ok SHALL therefore rise exactly LATENCY cycles after the acceptance cycle, and never otherwise.
REQ-020 At most one request SHALL be outstanding; maximum throughput is one request per LATENCY+1 cycles.
REQ-021 Word index SHALL be addr[ADDR_W+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo 2^(ADDR_W+2).
REQ-022 Alignment rule: a byte access is always aligned; a halfword access requires addr[0] == 0; a word access requires addr[1:0] == 0.
REQ-023 A request is erroneous if it is misaligned or has size == 3; it SHALL be accepted normally, SHALL never modify memory, and SHALL return err = 1 with data_ok.
REQ-024 Byte enables SHALL be derived from size and addr[1:0]: byte -> 1 << addr[1:0]; halfword -> 0011 or 1100; word -> 1111.
REQ-025 A write SHALL commit its enabled lanes of wdata to memory on the acceptance edge.
REQ-026 A read SHALL capture the full aligned word on the acceptance edge and hold it in rdata until data_ok; rdata is a don't-care when data_ok is low.
REQ-027 The pipeline performs lane extraction and sign extension; this block SHALL NOT.
REQ-028 For a write response, rdata SHALL be 0 and data_ok SHALL still pulse.
REQ-029 A read immediately following a write to the same word SHALL return the post-write value.
REQ-030 req, wr, size, addr and wdata SHALL be ignored outside the acceptance cycle.
REQ-031 err SHALL be 0 whenever data_ok is 0.

Reset
REQ-032 While resetn == 0: state SHALL be IDLE, counter 0, data_ok 0, err 0, rdata 0; addr_ok then follows REQ-015.
REQ-033 Reset asserted mid-operation (WAIT or RESP) SHALL drop the pending response with no data_ok pulse.
REQ-034 A write accepted before such a reset SHALL remain committed.
REQ-035 Memory contents SHALL NOT be cleared by reset; the bench initialises memory through writes.
REQ-036 After resetn deasserts, a req on the first clock edge SHALL be accepted.

Verification
REQ-037 Word write: LATENCY = 2; write size = 2, addr 0x100, wdata 0xDEADBEEF accepted at cycle t -> data_ok at t+2 with err = 0. Then read addr 0x100 -> rdata 0xDEADBEEF, err = 0.
REQ-038 Byte write: write size = 0, addr 0x102, wdata 0x00AA0000 over word 0xDEADBEEF -> a read of 0x100 returns 0xDEAABEEF.
REQ-039 Misaligned write: write size = 2, addr 0x101 -> data_ok with err = 1; a subsequent read of 0x100 returns an unchanged word.
REQ-040 Back-to-back requests: req held high continuously -> addr_ok pulses only in IDLE, spaced LATENCY+1 cycles apart; data_ok never overlaps addr_ok.
REQ-041 Address wrap: ADDR_W = 10; write 0x1234 to addr 0x00001000 -> a read of addr 0x00000000 returns 0x1234.
REQ-042 Reset mid-operation: resetn pulsed low during WAIT -> no data_ok appears; addr_ok accepts a new request on the first edge after release.
